fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction fetch stage of the pipeline. Resolves redirect requests (Jump, JumpM, Branch) into a single registered PC redirect, inserts a programmable number of flush bubbles after each redirect, and stalls fetch for one cycle on a load-use hazard. Sits between the EX/MEM stage control outputs and the `instruction_fetch` PC logic and pipeline registers.

## Interface
- `FLUSH_CYCLES`, 2, bubble cycles asserted after a redirect; legal range 1..7
- `XLEN`, 32, address/data width
- `Clk`  in  1  rising-edge clock
- `Rst_n`  in  1  reset, synchronous, active-low
- `Jump`  in  1  EX: unconditional jump, target `rs1`
- `JumpM`  in  1  MEM: jump to loaded value, target `read_data`
- `Branch`  in  1  EX: branch taken, target `ALU_result`
- `ALU_result`  in  XLEN  branch target
- `read_data`  in  XLEN  memory jump target
- `rs1`  in  XLEN  register jump target
- `load_use`  in  1  decode-stage load-use hazard
- `redirect_valid`  out  1  PC load strobe for fetch
- `redirect_pc`  out  XLEN  new PC value
- `pc_we`  out  1  PC write enable (0 = hold)
- `ifid_we`  out  1  IF/ID register write enable
- `ifid_flush`  out  1  clear IF/ID to NOP
- `idex_flush`  out  1  clear ID/EX to NOP
- `state`  out  2  debug: current FSM state

## Operation
- States: RUN(0), STALL(1), FLUSH(2). All outputs registered (Moore + registered redirect).
- Request priority: JumpM > Jump > Branch (JumpM is older, MEM stage). Jump+Branch together: Jump wins.
- RUN, any request at edge: next FLUSH; `redirect_valid`=1 and `redirect_pc`=selected target for exactly one cycle; counter loaded FLUSH_CYCLES-1.
- RUN, `load_use` and no request: next STALL.
- RUN, neither: stay RUN.
- STALL: `pc_we`=0, `ifid_we`=0, `idex_flush`=1 for one cycle. A request sampled in STALL takes priority: next FLUSH with redirect; else back to RUN. `load_use` still high re-enters STALL.
- FLUSH: `ifid_flush`=`idex_flush`=1, `pc_we`=1. `Jump`/`Branch`/`load_use` ignored (squashed instructions). `JumpM` in FLUSH honoured: restarts redirect and reloads counter. Counter 0 -> RUN.
- RUN outputs: `pc_we`=`ifid_we`=1, flushes 0, `redirect_valid`=0.
- `redirect_pc` holds last value when `redirect_valid`=0.

## Timing
- Reset (`Rst_n`=0 at edge): state RUN, counter 0, `redirect_valid`=0, `redirect_pc`=0, `pc_we`=1, `ifid_we`=1, `ifid_flush`=0, `idex_flush`=0. Reset mid-FLUSH/STALL aborts immediately; no pending redirect survives.
- Request sampled at edge t -> `redirect_valid` high during cycle t+1; flushes high cycles t+1..t+FLUSH_CYCLES; RUN at t+FLUSH_CYCLES+1.
- `load_use` at edge t -> stall outputs during cycle t+1 only.
- Redirect and `load_use` same edge: redirect only, no STALL.

## Configuration
- `FETCH_CTRL_PERF_EN` defined: adds outputs `redirect_cnt` and `stall_cnt` (32 bits, wrap at 2^32), incremented on each `redirect_valid` cycle and each STALL cycle; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package `fetch_ctrl_pkg`: state encoding (RUN/STALL/FLUSH), redirect cause encoding (NONE/JUMPM/JUMP/BRANCH), `FLUSH_CNT_W`=3.
- No sub-module in base build; with `FETCH_CTRL_PERF_EN`, two instances of `fetch_perf_cnt` (32-bit enable counter, sync active-low clear).

## Test plan
- Reset: hold `Rst_n`=0 two cycles with `Branch`=1 -> all outputs at reset values, state 0, no redirect.
- Branch, `ALU_result`=0x40, FLUSH_CYCLES=2 -> next cycle `redirect_valid`=1, `redirect_pc`=0x40; flushes high 2 cycles; state RUN on 3rd.
- `Jump`+`Branch`+`JumpM` together, `rs1`=0x10, `ALU_result`=0x20, `read_data`=0x30 -> `redirect_pc`=0x30; then repeat without JumpM -> 0x10.
- `load_use` 1 cycle -> one cycle `pc_we`=0, `ifid_we`=0, `idex_flush`=1; `load_use` 3 cycles -> 3 stall cycles.
- In FLUSH: `Branch` -> ignored; `JumpM` with `read_data`=0x80 -> second redirect to 0x80, flush window restarts.
- `Rst_n` low in second FLUSH cycle -> next cycle RUN, flushes 0; with `FETCH_CTRL_PERF_EN`, counters read 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the fetch sequencing controller:
//   - state_t     : controller FSM encoding (RUN / STALL / FLUSH)
//   - cause_t     : redirect cause encoding (NONE / JUMPM / JUMP / BRANCH)
//   - FLUSH_CNT_W : width of the flush bubble counter
//   - pick_cause  : fixed-priority redirect resolution
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    // Wide enough for a bubble count of up to 7 (loaded as FLUSH_CYCLES-1).
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_JUMPM  = 2'd1,
        CAUSE_JUMP   = 2'd2,
        CAUSE_BRANCH = 2'd3
    } cause_t;

    // JumpM comes from the MEM stage, so it belongs to an older instruction
    // than anything in EX and must win. Between the two EX requests, an
    // unconditional jump beats a taken branch.
    function automatic cause_t pick_cause(input logic jumpm,
                                          input logic jump,
                                          input logic branch);
        if (jumpm) begin
            return CAUSE_JUMPM;
        end else if (jump) begin
            return CAUSE_JUMP;
        end else if (branch) begin
            return CAUSE_BRANCH;
        end
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// -----------------------------------------------------------------------------
// fetch_perf_cnt
// 32-bit event counter used by fetch_ctrl when FETCH_CTRL_PERF_EN is defined.
// The whole module only exists in that build.
//
// Ports:
//   Clk    in   rising-edge clock
//   Rst_n  in   synchronous active-low clear
//   en     in   count enable; one increment per enabled cycle
//   count  out  [31:0] current count, wraps at 2^32
// -----------------------------------------------------------------------------
`ifdef FETCH_CTRL_PERF_EN
module fetch_perf_cnt (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Sequencing controller for the instruction fetch stage. Resolves the
// Jump / JumpM / Branch requests into one registered PC redirect, inserts
// FLUSH_CYCLES bubble cycles after each redirect and stalls fetch for one
// cycle per sampled load-use hazard.
//
// Optional feature macro: FETCH_CTRL_PERF_EN
//   When defined, adds redirect_cnt / stall_cnt performance counters.
//
// Parameters:
//   FLUSH_CYCLES  bubble cycles after a redirect (1..7)
//   XLEN          address / data width
//
// Ports:
//   Clk, Rst_n       clock, synchronous active-low reset
//   Jump             EX unconditional jump, target rs1
//   JumpM            MEM jump to loaded value, target read_data
//   Branch           EX taken branch, target ALU_result
//   ALU_result       [XLEN-1:0] branch target
//   read_data        [XLEN-1:0] memory jump target
//   rs1              [XLEN-1:0] register jump target
//   load_use         decode-stage load-use hazard
//   redirect_valid   one-cycle PC load strobe (no back-pressure: fetch must
//                    take redirect_pc in every cycle where this is high)
//   redirect_pc      [XLEN-1:0] new PC, holds its value while strobe is low
//   pc_we            PC write enable (0 = hold)
//   ifid_we          IF/ID write enable
//   ifid_flush       clear IF/ID to NOP
//   idex_flush       clear ID/EX to NOP
//   state            [1:0] debug view of the FSM state (state_t encoding)
//   redirect_cnt     [31:0] redirect strobes seen   (FETCH_CTRL_PERF_EN only)
//   stall_cnt        [31:0] STALL cycles seen       (FETCH_CTRL_PERF_EN only)
//
// Every output is driven straight from a flop; the next-cycle values are
// decoded from the next state so no combinational path reaches the ports.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Jump,
    input  logic            JumpM,
    input  logic            Branch,
    input  logic [XLEN-1:0] ALU_result,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] rs1,
    input  logic            load_use,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic [1:0]      state
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    // The counter runs FLUSH_CYCLES-1 down to 0, so the FLUSH state lasts
    // exactly FLUSH_CYCLES cycles.
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_t                 cur_state;
    state_t                 nxt_state;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] nxt_cnt;
    cause_t                 req_cause;
    cause_t                 sel_cause;
    logic                   nxt_valid;
    logic [XLEN-1:0]        nxt_pc;
    logic                   nxt_pc_we;
    logic                   nxt_ifid_we;
    logic                   nxt_ifid_flush;
    logic                   nxt_idex_flush;

    assign state = cur_state;

    // -------------------------------------------------------------------------
    // Next-state, redirect selection and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        nxt_state      = cur_state;
        nxt_cnt        = flush_cnt;
        sel_cause      = CAUSE_NONE;
        req_cause      = pick_cause(JumpM, Jump, Branch);

        case (cur_state)
            ST_RUN, ST_STALL: begin
                // A redirect outranks a hazard on the same edge: the stalled
                // instruction is about to be flushed anyway.
                if (req_cause != CAUSE_NONE) begin
                    sel_cause = req_cause;
                    nxt_state = ST_FLUSH;
                    nxt_cnt   = FLUSH_LOAD;
                end else if (load_use) begin
                    nxt_state = ST_STALL;
                end else begin
                    nxt_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Jump/Branch/load_use now come from squashed instructions.
                // Only JumpM, from an older instruction in MEM, is still live;
                // it redirects again and reopens the bubble window.
                if (JumpM) begin
                    sel_cause = CAUSE_JUMPM;
                    nxt_state = ST_FLUSH;
                    nxt_cnt   = FLUSH_LOAD;
                end else if (flush_cnt == '0) begin
                    nxt_state = ST_RUN;
                end else begin
                    nxt_cnt = flush_cnt - FLUSH_CNT_W'(1);
                end
            end
            default: begin
                nxt_state = ST_RUN;
                nxt_cnt   = '0;
            end
        endcase

        nxt_valid = (sel_cause != CAUSE_NONE);

        case (sel_cause)
            CAUSE_JUMPM:  nxt_pc = read_data;
            CAUSE_JUMP:   nxt_pc = rs1;
            CAUSE_BRANCH: nxt_pc = ALU_result;
            default:      nxt_pc = redirect_pc;
        endcase

        nxt_pc_we      = 1'b1;
        nxt_ifid_we    = 1'b1;
        nxt_ifid_flush = 1'b0;
        nxt_idex_flush = 1'b0;
        case (nxt_state)
            ST_STALL: begin
                // Hold PC and IF/ID, inject a bubble into ID/EX.
                nxt_pc_we      = 1'b0;
                nxt_ifid_we    = 1'b0;
                nxt_idex_flush = 1'b1;
            end
            ST_FLUSH: begin
                nxt_ifid_flush = 1'b1;
                nxt_idex_flush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cur_state      <= ST_RUN;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            pc_we          <= 1'b1;
            ifid_we        <= 1'b1;
            ifid_flush     <= 1'b0;
            idex_flush     <= 1'b0;
        end else begin
            cur_state      <= nxt_state;
            flush_cnt      <= nxt_cnt;
            redirect_valid <= nxt_valid;
            redirect_pc    <= nxt_pc;
            pc_we          <= nxt_pc_we;
            ifid_we        <= nxt_ifid_we;
            ifid_flush     <= nxt_ifid_flush;
            idex_flush     <= nxt_idex_flush;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters: count the cycles the strobe / stall are visible.
    // -------------------------------------------------------------------------
    fetch_perf_cnt u_redirect_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .en    (redirect_valid),
        .count (redirect_cnt)
    );

    fetch_perf_cnt u_stall_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .en    (cur_state == ST_STALL),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl (FLUSH_CYCLES = 2, XLEN = 32).
// Directed vector table, a hand-written JumpM chain, then random traffic,
// all scored against a bubble-counting reference model.
// Covers FETCH_CTRL_PERF_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int FC = 2;
    localparam logic [3:0] RUNF = 4'b1100;  // {pc_we, ifid_we, ifid_flush, idex_flush}
    localparam logic [3:0] STF  = 4'b0001;
    localparam logic [3:0] FLF  = 4'b1111;

    // ---------------- clock / reset -----------------------------------------
    logic        Clk;
    logic        Rst_n;
    logic        Jump, JumpM, Branch, load_use;
    logic [31:0] ALU_result, read_data, rs1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pc_we, ifid_we, ifid_flush, idex_flush;
    logic [1:0]  state;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] redirect_cnt, stall_cnt;
`endif

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    fetch_ctrl #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Jump           (Jump),
        .JumpM          (JumpM),
        .Branch         (Branch),
        .ALU_result     (ALU_result),
        .read_data      (read_data),
        .rs1            (rs1),
        .load_use       (load_use),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .state          (state)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .redirect_cnt   (redirect_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    // ---------------- counters ----------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int cycle_no = 0;

    // ---------------- reference model ---------------------------------------
    // m_bubbles = flush cycles still to be shown, including the current one.
    int          m_bubbles = 0;
    bit          m_stalled = 1'b0;
    bit          m_rv      = 1'b0;
    logic [31:0] m_pc      = '0;
    logic [31:0] m_rcnt    = '0;
    logic [31:0] m_scnt    = '0;

    function automatic void model_step(input bit rn, jm, j, br, lu,
                                       input logic [31:0] alu, rd, r1);
        if (!rn) begin
            m_bubbles = 0; m_stalled = 1'b0; m_rv = 1'b0; m_pc = '0;
            m_rcnt = '0; m_scnt = '0;
            return;
        end
        if (m_rv)      m_rcnt = m_rcnt + 32'd1;
        if (m_stalled) m_scnt = m_scnt + 32'd1;
        if (m_bubbles > 0) begin
            m_stalled = 1'b0;
            if (jm) begin
                m_rv = 1'b1; m_pc = rd; m_bubbles = FC;
            end else begin
                m_rv = 1'b0; m_bubbles = m_bubbles - 1;
            end
        end else if (jm || j || br) begin
            m_rv = 1'b1;
            m_pc = jm ? rd : (j ? r1 : alu);
            m_bubbles = FC;
            m_stalled = 1'b0;
        end else begin
            m_rv = 1'b0;
            m_stalled = lu;
        end
    endfunction

    function automatic logic [38:0] model_vec();
        bit flushing;
        logic [1:0] st;
        flushing = (m_bubbles > 0);
        st = flushing ? 2'd2 : (m_stalled ? 2'd1 : 2'd0);
        return {m_rv, m_pc, ~m_stalled, ~m_stalled, flushing, flushing | m_stalled, st};
    endfunction

    function automatic logic [38:0] dut_vec();
        return {redirect_valid, redirect_pc, pc_we, ifid_we, ifid_flush, idex_flush, state};
    endfunction

    // ---------------- scoreboard --------------------------------------------
    logic [38:0] exp_q[$];

    task automatic sb_check();
        logic [38:0] exp_v;
        logic [38:0] got_v;
        exp_v = exp_q.pop_front();
        got_v = dut_vec();
        n_checks++;
        if (got_v === exp_v) n_pass++;
        else $display("FAIL sb cycle %0d: got %h required %h", cycle_no, got_v, exp_v);
`ifdef FETCH_CTRL_PERF_EN
        n_checks++;
        if (redirect_cnt === m_rcnt && stall_cnt === m_scnt) n_pass++;
        else $display("FAIL perf cycle %0d: got %0d/%0d required %0d/%0d",
                      cycle_no, redirect_cnt, stall_cnt, m_rcnt, m_scnt);
`endif
    endtask

    // ---------------- driver ------------------------------------------------
    task automatic do_cycle(input bit rn, jm, j, br, lu,
                            input logic [31:0] alu, rd, r1,
                            output logic [38:0] got);
        Rst_n = rn; JumpM = jm; Jump = j; Branch = br; load_use = lu;
        ALU_result = alu; read_data = rd; rs1 = r1;
        model_step(rn, jm, j, br, lu, alu, rd, r1);
        exp_q.push_back(model_vec());
        @(posedge Clk);
        #1;
        cycle_no++;
        got = dut_vec();
        sb_check();
    endtask

    // ---------------- directed vectors --------------------------------------
    typedef struct {
        bit          rn, jm, j, br, lu;
        logic [31:0] alu, rd, r1;
        bit          rv;
        logic [31:0] pc;
        logic [1:0]  st;
        logic [3:0]  flags;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    function automatic vec_t mk(input bit rn, jm, j, br, lu,
                                input logic [31:0] alu, rd, r1,
                                input bit rv, input logic [31:0] pc,
                                input logic [1:0] st, input logic [3:0] flags);
        vec_t v;
        v.rn = rn; v.jm = jm; v.j = j; v.br = br; v.lu = lu;
        v.alu = alu; v.rd = rd; v.r1 = r1;
        v.rv = rv; v.pc = pc; v.st = st; v.flags = flags;
        return v;
    endfunction

    initial begin
        logic [38:0] got;
        logic [38:0] want;

        Rst_n = 1'b0; Jump = 1'b0; JumpM = 1'b0; Branch = 1'b0; load_use = 1'b0;
        ALU_result = '0; read_data = '0; rs1 = '0;

        //            rn jm j  br lu alu    rd     r1     rv pc     st flags
        vecs[0]  = mk(0, 0, 0, 1, 0, 32'h40, 0,     0,     0, 32'h0,  0, RUNF);
        vecs[1]  = mk(0, 0, 0, 1, 0, 32'h40, 0,     0,     0, 32'h0,  0, RUNF);
        vecs[2]  = mk(1, 0, 0, 1, 0, 32'h40, 0,     0,     1, 32'h40, 2, FLF);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h40, 2, FLF);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h40, 0, RUNF);
        vecs[5]  = mk(1, 1, 1, 1, 0, 32'h20, 32'h30, 32'h10, 1, 32'h30, 2, FLF);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h30, 2, FLF);
        vecs[7]  = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h30, 0, RUNF);
        vecs[8]  = mk(1, 0, 1, 1, 0, 32'h20, 32'h30, 32'h10, 1, 32'h10, 2, FLF);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h10, 2, FLF);
        vecs[10] = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h10, 0, RUNF);
        vecs[11] = mk(1, 0, 0, 0, 1, 0,      0,     0,     0, 32'h10, 1, STF);
        vecs[12] = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h10, 0, RUNF);
        vecs[13] = mk(1, 0, 0, 0, 1, 0,      0,     0,     0, 32'h10, 1, STF);
        vecs[14] = mk(1, 0, 0, 0, 1, 0,      0,     0,     0, 32'h10, 1, STF);
        vecs[15] = mk(1, 0, 0, 0, 1, 0,      0,     0,     0, 32'h10, 1, STF);
        vecs[16] = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h10, 0, RUNF);
        vecs[17] = mk(1, 0, 0, 1, 0, 32'h50, 0,     0,     1, 32'h50, 2, FLF);
        vecs[18] = mk(1, 0, 0, 1, 0, 32'h60, 0,     0,     0, 32'h50, 2, FLF);
        vecs[19] = mk(1, 1, 0, 0, 0, 0,      32'h80, 0,    1, 32'h80, 2, FLF);
        vecs[20] = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h80, 2, FLF);
        vecs[21] = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h80, 0, RUNF);
        vecs[22] = mk(1, 0, 0, 1, 1, 32'h90, 0,     0,     1, 32'h90, 2, FLF);
        vecs[23] = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'h90, 2, FLF);
        vecs[24] = mk(0, 0, 0, 0, 0, 0,      0,     0,     0, 32'h0,  0, RUNF);
        vecs[25] = mk(1, 0, 0, 0, 1, 0,      0,     0,     0, 32'h0,  1, STF);
        vecs[26] = mk(1, 0, 0, 1, 1, 32'hA0, 0,     0,     1, 32'hA0, 2, FLF);
        vecs[27] = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'hA0, 2, FLF);
        vecs[28] = mk(1, 0, 0, 0, 1, 0,      0,     0,     0, 32'hA0, 0, RUNF);
        vecs[29] = mk(1, 0, 0, 0, 0, 0,      0,     0,     0, 32'hA0, 0, RUNF);

        for (int i = 0; i < NV; i++) begin
            do_cycle(vecs[i].rn, vecs[i].jm, vecs[i].j, vecs[i].br, vecs[i].lu,
                     vecs[i].alu, vecs[i].rd, vecs[i].r1, got);
            want = {vecs[i].rv, vecs[i].pc, vecs[i].flags, vecs[i].st};
            n_checks++;
            if (got === want) n_pass++;
            else $display("FAIL vec%0d: got %h required %h", i, got, want);
`ifdef FETCH_CTRL_PERF_EN
            if (i == 24) begin
                n_checks++;
                if (redirect_cnt === 32'd0 && stall_cnt === 32'd0) n_pass++;
                else $display("FAIL perf_reset: got %0d/%0d required 0/0",
                              redirect_cnt, stall_cnt);
            end
`endif
        end

        // Hand sequence: JumpM every cycle keeps the bubble window open and
        // re-targets the PC each time; then it drains to RUN after FC cycles.
        for (int k = 0; k < 4; k++) begin
            do_cycle(1, 1, 0, 0, 0, 0, 32'h100 + 32'(k) * 4, 0, got);
            n_checks++;
            if (got[38] === 1'b1 && got[37:6] === (32'h100 + 32'(k) * 4) && got[1:0] === 2'd2)
                n_pass++;
            else $display("FAIL jumpm_chain%0d: got %h required rv=1 pc=%h state=2",
                          k, got, 32'h100 + 32'(k) * 4);
        end
        for (int k = 0; k < FC; k++) begin
            do_cycle(1, 0, 1, 1, 1, 32'h5, 0, 32'h6, got);
        end
        n_checks++;
        if (got[1:0] === 2'd0 && got[38] === 1'b0) n_pass++;
        else $display("FAIL jumpm_drain: got state %0d rv %0d required state 0 rv 0",
                      got[1:0], got[38]);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            bit rn, jm, j, br, lu;
            rn = ($urandom_range(0, 63) != 0);
            jm = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 5) == 0);
            br = ($urandom_range(0, 4) == 0);
            lu = ($urandom_range(0, 3) == 0);
            do_cycle(rn, jm, j, br, lu, $urandom, $urandom, $urandom, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
